// File: rtl/instruction_decode_hz.sv
// instruction_decode_hz
//   DLX instruction decode stage. Decodes the instruction presented by the
//   IF/ID register and reads its operands from an internal register bank.
//   A write-back port updates the bank, and an optional bypass forwards a
//   same-cycle write to the read ports. A load-use hazard stalls IF for one
//   cycle. The result is captured in a valid-tagged ID/EX register.
// Ports:
//   clk, rst            clock and asynchronous active-high reset
//   if_valid_in, instruction_in, new_pc_in, id_ready_out
//                       upstream valid/ready handshake with IF/ID
//   flush_in            discard the instruction currently in ID
//   wb_write_*          register bank write-back port
//   ex_valid_out and the remaining *_out ports
//                       registered ID/EX contents
module instruction_decode_hz #(
  parameter int PC_WIDTH          = 20,
  parameter int DATA_WIDTH        = 32,
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int REG_ADDR_WIDTH    = 5,
  parameter int OPCODE_WIDTH      = 6,
  parameter int FUNCTION_WIDTH    = 6,
  parameter int IMEDIATE_WIDTH    = 16,
  parameter int PC_OFFSET_WIDTH   = 26,
  parameter int ZERO_REG          = 1,
  parameter int WB_BYPASS         = 1,
  parameter int HAZARD_DETECT     = 1,
  parameter int ZERO_EXT_LOGIC    = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         if_valid_in,
  input  logic [INSTRUCTION_WIDTH-1:0] instruction_in,
  input  logic [PC_WIDTH-1:0]          new_pc_in,
  output logic                         id_ready_out,
  input  logic                         flush_in,
  input  logic                         wb_write_enable,
  input  logic [REG_ADDR_WIDTH-1:0]    wb_write_addr,
  input  logic [DATA_WIDTH-1:0]        wb_write_data,
  output logic                         ex_valid_out,
  output logic [OPCODE_WIDTH-1:0]      opcode_out,
  output logic [FUNCTION_WIDTH-1:0]    inst_function_out,
  output logic [REG_ADDR_WIDTH-1:0]    read_address1_out,
  output logic [REG_ADDR_WIDTH-1:0]    read_address2_out,
  output logic [REG_ADDR_WIDTH-1:0]    reg_wr_addr_out,
  output logic                         reg_wr_en_out,
  output logic                         mem_data_rd_en_out,
  output logic                         mem_data_wr_en_out,
  output logic                         write_back_mux_sel_out,
  output logic                         imm_inst_out,
  output logic [DATA_WIDTH-1:0]        constant_out,
  output logic [DATA_WIDTH-1:0]        data_alu_a_out,
  output logic [DATA_WIDTH-1:0]        data_alu_b_out,
  output logic [PC_WIDTH-1:0]          new_pc_out,
  output logic [PC_OFFSET_WIDTH-1:0]   pc_offset_out,
  output logic                         branch_inst_out,
  output logic                         jump_inst_out,
  output logic                         jump_use_r_out
);

  localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;
  localparam int OP_LSB   = INSTRUCTION_WIDTH - OPCODE_WIDTH;
  localparam int RS1_LSB  = OP_LSB - REG_ADDR_WIDTH;
  localparam int RS2_LSB  = RS1_LSB - REG_ADDR_WIDTH;
  localparam int RD_LSB   = IMEDIATE_WIDTH - REG_ADDR_WIDTH;

  typedef struct packed {
    logic                       valid;
    logic [OPCODE_WIDTH-1:0]    opcode;
    logic [FUNCTION_WIDTH-1:0]  funct;
    logic [REG_ADDR_WIDTH-1:0]  rs1;
    logic [REG_ADDR_WIDTH-1:0]  rs2;
    logic [REG_ADDR_WIDTH-1:0]  wr_addr;
    logic                       wr_en;
    logic                       mem_rd;
    logic                       mem_wr;
    logic                       wb_sel;
    logic                       imm;
    logic [DATA_WIDTH-1:0]      konst;
    logic [DATA_WIDTH-1:0]      data_a;
    logic [DATA_WIDTH-1:0]      data_b;
    logic [PC_WIDTH-1:0]        pc;
    logic [PC_OFFSET_WIDTH-1:0] offset;
    logic                       branch;
    logic                       jump;
    logic                       use_r;
  } ex_t;

  ex_t ex_q, ex_d, dec;
  logic [DATA_WIDTH-1:0] bank_q [NUM_REGS];

  logic                      bank_we;
  logic [OPCODE_WIDTH-1:0]   opcode;
  logic [31:0]               op_u;
  logic [REG_ADDR_WIDTH-1:0] rs1, rs2;
  logic [IMEDIATE_WIDTH-1:0] imm_field;
  logic                      rs1_used, rs2_used, writes, hazard;

  assign bank_we = wb_write_enable && !(ZERO_REG != 0 && wb_write_addr == '0);

  // Register bank: a write to r0 is dropped when r0 is hard-wired to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) bank_q[i] <= '0;
    end else if (bank_we) begin
      bank_q[wb_write_addr] <= wb_write_data;
    end
  end

  function automatic logic [DATA_WIDTH-1:0] read_reg(input logic [REG_ADDR_WIDTH-1:0] addr);
    if (ZERO_REG != 0 && addr == '0)
      return '0;
    else if (WB_BYPASS != 0 && bank_we && wb_write_addr == addr)
      return wb_write_data;
    else
      return bank_q[addr];
  endfunction

  assign opcode    = instruction_in[OP_LSB +: OPCODE_WIDTH];
  assign op_u      = 32'(opcode);
  assign rs1       = instruction_in[RS1_LSB +: REG_ADDR_WIDTH];
  assign rs2       = instruction_in[RS2_LSB +: REG_ADDR_WIDTH];
  assign imm_field = instruction_in[IMEDIATE_WIDTH-1:0];

  always_comb begin
    dec      = '0;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    writes   = 1'b0;
    dec.valid   = 1'b1;
    dec.opcode  = opcode;
    dec.funct   = instruction_in[FUNCTION_WIDTH-1:0];
    dec.rs1     = rs1;
    dec.rs2     = rs2;
    dec.pc      = new_pc_in;
    dec.offset  = instruction_in[PC_OFFSET_WIDTH-1:0];
    dec.data_a  = read_reg(rs1);
    dec.data_b  = read_reg(rs2);
    dec.konst   = {{(DATA_WIDTH-IMEDIATE_WIDTH){imm_field[IMEDIATE_WIDTH-1]}}, imm_field};
    if (ZERO_EXT_LOGIC != 0 && op_u >= 32'h0C && op_u <= 32'h0E)
      dec.konst = {{(DATA_WIDTH-IMEDIATE_WIDTH){1'b0}}, imm_field};

    if (op_u == 32'h00) begin
      rs1_used = 1'b1; rs2_used = 1'b1; writes = 1'b1;
      dec.wr_addr = instruction_in[RD_LSB +: REG_ADDR_WIDTH];
    end else if (op_u >= 32'h08 && op_u <= 32'h1F && op_u != 32'h12 && op_u != 32'h13) begin
      rs1_used = 1'b1; writes = 1'b1; dec.imm = 1'b1;
      dec.wr_addr = rs2;
    end else if (op_u >= 32'h20 && op_u <= 32'h25) begin
      rs1_used = 1'b1; writes = 1'b1; dec.imm = 1'b1;
      dec.mem_rd = 1'b1; dec.wb_sel = 1'b1;
      dec.wr_addr = rs2;
    end else if (op_u >= 32'h28 && op_u <= 32'h2B) begin
      rs1_used = 1'b1; rs2_used = 1'b1; dec.imm = 1'b1; dec.mem_wr = 1'b1;
    end else if (op_u == 32'h04 || op_u == 32'h05) begin
      rs1_used = 1'b1; dec.branch = 1'b1;
    end else if (op_u == 32'h02) begin
      dec.jump = 1'b1;
    end else if (op_u == 32'h03) begin
      dec.jump = 1'b1; writes = 1'b1;
      dec.wr_addr = REG_ADDR_WIDTH'(31);
    end else if (op_u == 32'h12 || op_u == 32'h13) begin
      rs1_used = 1'b1; dec.jump = 1'b1; dec.use_r = 1'b1;
      if (op_u == 32'h13) begin
        writes = 1'b1;
        dec.wr_addr = REG_ADDR_WIDTH'(31);
      end
    end
    dec.wr_en = writes && !(ZERO_REG != 0 && dec.wr_addr == '0);
  end

  // A load in EX whose destination feeds an operand of the ID instruction.
  assign hazard = (HAZARD_DETECT != 0) && if_valid_in && ex_q.valid && ex_q.mem_rd &&
                  (ex_q.wr_addr != '0) &&
                  ((rs1_used && rs1 == ex_q.wr_addr) || (rs2_used && rs2 == ex_q.wr_addr));

  assign id_ready_out = !hazard || flush_in;

  // Flush, stall and idle all load a bubble; a stall lasts one cycle because
  // the bubble removes the load from EX.
  always_comb begin
    ex_d = dec;
    if (flush_in || hazard || !if_valid_in) ex_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ex_q <= '0;
    else     ex_q <= ex_d;
  end

  assign ex_valid_out           = ex_q.valid;
  assign opcode_out             = ex_q.opcode;
  assign inst_function_out      = ex_q.funct;
  assign read_address1_out      = ex_q.rs1;
  assign read_address2_out      = ex_q.rs2;
  assign reg_wr_addr_out        = ex_q.wr_addr;
  assign reg_wr_en_out          = ex_q.wr_en;
  assign mem_data_rd_en_out     = ex_q.mem_rd;
  assign mem_data_wr_en_out     = ex_q.mem_wr;
  assign write_back_mux_sel_out = ex_q.wb_sel;
  assign imm_inst_out           = ex_q.imm;
  assign constant_out           = ex_q.konst;
  assign data_alu_a_out         = ex_q.data_a;
  assign data_alu_b_out         = ex_q.data_b;
  assign new_pc_out             = ex_q.pc;
  assign pc_offset_out          = ex_q.offset;
  assign branch_inst_out        = ex_q.branch;
  assign jump_inst_out          = ex_q.jump;
  assign jump_use_r_out         = ex_q.use_r;

endmodule
